// File: rtl/scsi_sd_pkg.sv
// Shared types and sizes for the SCSI target <-> block-storage sector bridge.
package scsi_sd_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_AW    = 9;
  localparam int CNT_W        = SECTOR_AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_CMD,
    WR_FETCH,
    WR_DATA,
    ACK
  } state_t;

endpackage

// File: rtl/scsi_sd_bridge.sv
// Moves one 512-byte sector per SCSI io request between the target buffers and block storage.
// Optional LBA range check against CAPACITY is enabled with `define SCSI_SD_BOUNDS_CHECK_EN.
module scsi_sd_bridge
  import scsi_sd_pkg::*;
#(
  parameter logic [31:0] BASE_LBA = 32'd0,
  parameter logic [31:0] CAPACITY = 32'd41056
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          io_lba,
  input  logic                 io_rd,
  input  logic                 io_wr,
  output logic                 io_ack,
  output logic                 io_err,
  output logic [SECTOR_AW-1:0] sd_buff_addr,
  output logic [7:0]           sd_buff_dout,
  output logic                 sd_buff_wr,
  input  logic [7:0]           sd_buff_din,
  output logic [31:0]          blk_lba,
  output logic                 blk_rd,
  output logic                 blk_wr,
  input  logic                 blk_ack,
  input  logic [7:0]           blk_din,
  input  logic                 blk_din_valid,
  output logic [7:0]           blk_dout,
  output logic                 blk_dout_valid,
  input  logic                 blk_dout_ready
);

`ifdef SCSI_SD_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] count;
  logic             err_q;
  logic             last;
  logic             out_of_range;

  assign last         = (count == CNT_W'(SECTOR_BYTES - 1));
  assign out_of_range = BOUNDS_EN && (io_lba >= CAPACITY);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    io_ack         = 1'b0;
    io_err         = 1'b0;
    blk_rd         = 1'b0;
    blk_wr         = 1'b0;
    blk_dout_valid = 1'b0;
    case (state)
      IDLE: begin
        if (io_rd || io_wr) begin
          if (out_of_range) state_nx = ACK;
          else if (io_rd)   state_nx = RD_CMD;
          else              state_nx = WR_CMD;
        end
      end
      RD_CMD: begin
        blk_rd = 1'b1;
        if (blk_ack) state_nx = RD_DATA;
      end
      RD_DATA: begin
        if (blk_din_valid && last) state_nx = ACK;
      end
      WR_CMD: begin
        blk_wr = 1'b1;
        if (blk_ack) state_nx = WR_FETCH;
      end
      WR_FETCH: state_nx = WR_DATA;
      WR_DATA: begin
        blk_dout_valid = 1'b1;
        if (blk_dout_ready) state_nx = last ? ACK : WR_FETCH;
      end
      ACK: begin
        io_ack   = 1'b1;
        io_err   = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Buffer address runs one byte ahead during writes so sd_buff_din is
  // already valid when WR_FETCH loads blk_dout (2 cycles per byte).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= '0;
      sd_buff_addr <= '0;
      sd_buff_wr   <= 1'b0;
      blk_lba      <= '0;
      err_q        <= 1'b0;
    end else begin
      sd_buff_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (io_rd || io_wr) begin
            blk_lba      <= io_lba + BASE_LBA;
            count        <= '0;
            sd_buff_addr <= '0;
            err_q        <= out_of_range;
          end
        end
        RD_DATA: begin
          if (blk_din_valid) begin
            sd_buff_wr   <= 1'b1;
            sd_buff_addr <= count[SECTOR_AW-1:0];
            count        <= count + 1'b1;
          end
        end
        WR_FETCH: begin
          if (!last) sd_buff_addr <= sd_buff_addr + 1'b1;
        end
        WR_DATA: begin
          if (blk_dout_ready && !last) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RD_DATA && blk_din_valid) sd_buff_dout <= blk_din;
    if (state == WR_FETCH)                 blk_dout     <= sd_buff_din;
  end

endmodule

// File: tb/tb_scsi_sd_bridge.sv
// Directed bench for scsi_sd_bridge (BASE_LBA=100); bounds cases follow SCSI_SD_BOUNDS_CHECK_EN.
module tb_scsi_sd_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io_lba;
  logic        io_rd, io_wr;
  logic        io_ack, io_err;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [31:0] blk_lba;
  logic        blk_rd, blk_wr, blk_ack;
  logic [7:0]  blk_din;
  logic        blk_din_valid;
  logic [7:0]  blk_dout;
  logic        blk_dout_valid, blk_dout_ready;

  int checks = 0;
  int failures = 0;
  int ack_count = 0;
  int wr_seen = 0;
  int rd_seen = 0;
  int exp_acks = 0;
  logic [7:0] wbuf [512];

  scsi_sd_bridge #(.BASE_LBA(32'd100), .CAPACITY(32'd41056)) dut (
    .clk(clk), .rst_n(rst_n), .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr),
    .io_ack(io_ack), .io_err(io_err), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .blk_lba(blk_lba), .blk_rd(blk_rd), .blk_wr(blk_wr), .blk_ack(blk_ack),
    .blk_din(blk_din), .blk_din_valid(blk_din_valid), .blk_dout(blk_dout),
    .blk_dout_valid(blk_dout_valid), .blk_dout_ready(blk_dout_ready)
  );

  always #5 clk = ~clk;

  // Target outbound buffer: synchronous read, one cycle after the address.
  always @(posedge clk) sd_buff_din <= wbuf[sd_buff_addr];

  always @(posedge clk) begin
    if (io_ack === 1'b1) ack_count <= ack_count + 1;
    if (blk_wr === 1'b1) wr_seen   <= wr_seen + 1;
    if (blk_rd === 1'b1) rd_seen   <= rd_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] lba, input logic [31:0] exp_lba,
                         input bit both, input int abort_at);
    int n;
    int bad;
    io_lba = lba;
    io_rd  = 1'b1;
    io_wr  = both;
    @(negedge clk);
    n = 0;
    while (blk_rd !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_blk_rd"}, {31'd0, blk_rd}, 32'd1);
    chk({tag, "_blk_lba"}, blk_lba, exp_lba);
    io_lba = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    chk({tag, "_rd_held"}, {31'd0, blk_rd}, 32'd1);
    blk_ack = 1'b1;
    @(negedge clk);
    blk_ack = 1'b0;
    chk({tag, "_rd_drop"}, {31'd0, blk_rd}, 32'd0);
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (i % 37 == 5) begin
        blk_din_valid = 1'b0;
        @(negedge clk);
        if (sd_buff_wr !== 1'b0) bad++;
      end
      blk_din_valid = 1'b1;
      blk_din       = i[7:0];
      @(negedge clk);
      blk_din_valid = 1'b0;
      if (sd_buff_wr !== 1'b1 || sd_buff_addr !== i[8:0] || sd_buff_dout !== i[7:0]) bad++;
      if (i < 511 && io_ack !== 1'b0) bad++;
      if (i == abort_at) begin
        chk({tag, "_bytes_before_abort"}, bad, 0);
        return;
      end
    end
    chk({tag, "_bytes"}, bad, 0);
    chk({tag, "_ack"}, {31'd0, io_ack}, 32'd1);
    chk({tag, "_err"}, {31'd0, io_err}, 32'd0);
    chk({tag, "_lba_kept"}, blk_lba, exp_lba);
    exp_acks++;
    io_rd = 1'b0;
    io_wr = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_one_cycle"}, {31'd0, io_ack}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] lba, input logic [31:0] exp_lba);
    int n;
    int bad;
    int idx;
    int cyc;
    io_lba = lba;
    io_wr  = 1'b1;
    @(negedge clk);
    n = 0;
    while (blk_wr !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("wr_blk_wr", {31'd0, blk_wr}, 32'd1);
    chk("wr_blk_lba", blk_lba, exp_lba);
    chk("wr_no_rd", {31'd0, blk_rd}, 32'd0);
    repeat (2) @(negedge clk);
    chk("wr_held", {31'd0, blk_wr}, 32'd1);
    blk_ack = 1'b1;
    @(negedge clk);
    blk_ack = 1'b0;
    chk("wr_drop", {31'd0, blk_wr}, 32'd0);
    bad = 0;
    idx = 0;
    cyc = 0;
    while (idx < 512 && cyc < 5000) begin
      blk_dout_ready = (cyc % 2 == 1);
      if (blk_dout_valid === 1'b1) begin
        if (blk_dout !== (idx[7:0] ^ 8'h5A)) bad++;
        if (blk_dout_ready) idx++;
      end
      @(negedge clk);
      cyc++;
    end
    blk_dout_ready = 1'b0;
    chk("wr_byte_count", idx, 512);
    chk("wr_bytes", bad, 0);
    chk("wr_ack", {31'd0, io_ack}, 32'd1);
    chk("wr_err", {31'd0, io_err}, 32'd0);
    chk("wr_valid_off", {31'd0, blk_dout_valid}, 32'd0);
    exp_acks++;
    io_wr = 1'b0;
    @(negedge clk);
    chk("wr_ack_one_cycle", {31'd0, io_ack}, 32'd0);
  endtask

  initial begin
    int snap;
    for (int a = 0; a < 512; a++) wbuf[a] = a[7:0] ^ 8'h5A;
    rst_n = 1'b0;
    io_lba = '0; io_rd = 1'b0; io_wr = 1'b0;
    blk_ack = 1'b0; blk_din = '0; blk_din_valid = 1'b0; blk_dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_io_ack", {31'd0, io_ack}, 32'd0);
    chk("rst_io_err", {31'd0, io_err}, 32'd0);
    chk("rst_buff_wr", {31'd0, sd_buff_wr}, 32'd0);
    chk("rst_blk_rd", {31'd0, blk_rd}, 32'd0);
    chk("rst_blk_wr", {31'd0, blk_wr}, 32'd0);
    chk("rst_dout_valid", {31'd0, blk_dout_valid}, 32'd0);
    chk("rst_addr", {23'd0, sd_buff_addr}, 32'd0);
    chk("rst_blk_lba", blk_lba, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_read("rd", 32'd5, 32'd105, 1'b0, -1);
    chk("rd_ack_total", ack_count, exp_acks);

    do_write(32'd20, 32'd120);
    chk("wr_ack_total", ack_count, exp_acks);

    snap = wr_seen;
    do_read("both", 32'd7, 32'd107, 1'b1, -1);
    chk("both_no_wr", wr_seen, snap);

    do_read("abort", 32'd3, 32'd103, 1'b0, 200);
    rst_n = 1'b0;
    io_rd = 1'b0;
    @(negedge clk);
    chk("abort_ack", {31'd0, io_ack}, 32'd0);
    chk("abort_buff_wr", {31'd0, sd_buff_wr}, 32'd0);
    chk("abort_blk_rd", {31'd0, blk_rd}, 32'd0);
    chk("abort_addr", {23'd0, sd_buff_addr}, 32'd0);
    chk("abort_blk_lba", blk_lba, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", ack_count, exp_acks);
    do_read("after_abort", 32'd9, 32'd109, 1'b0, -1);

`ifdef SCSI_SD_BOUNDS_CHECK_EN
    snap = rd_seen;
    io_lba = 32'd41056;
    io_rd  = 1'b1;
    @(negedge clk);
    chk("oob_ack", {31'd0, io_ack}, 32'd1);
    chk("oob_err", {31'd0, io_err}, 32'd1);
    chk("oob_buff_wr", {31'd0, sd_buff_wr}, 32'd0);
    exp_acks++;
    io_rd = 1'b0;
    @(negedge clk);
    chk("oob_ack_one_cycle", {31'd0, io_ack}, 32'd0);
    chk("oob_no_blk_rd", rd_seen, snap);
    do_read("last_sector", 32'd41055, 32'd41155, 1'b0, -1);
`else
    do_read("no_bounds", 32'd41056, 32'd41156, 1'b0, -1);
`endif

    snap = ack_count;
    do_read("b2b_a", 32'd11, 32'd111, 1'b0, -1);
    do_read("b2b_b", 32'd12, 32'd112, 1'b0, -1);
    repeat (3) @(negedge clk);
    chk("b2b_two_acks", ack_count - snap, 2);
    chk("total_acks", ack_count, exp_acks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/scsi_sd_bridge.md
Name: scsi_sd_bridge

Overview:
Services the SCSI target's sector requests (io_rd/io_wr/io_lba/io_ack) against a byte-streaming block-storage port (SD/SPI card controller or image server).
- Reads: moves one 512-byte sector from storage into the target's inbound buffer via sd_buff_addr/sd_buff_dout/sd_buff_wr.
- Writes: streams the target's outbound buffer (sd_buff_din) to storage.
- Sits directly between the SCSI target and the storage controller; one sector per io request.

Parameters:
BASE_LBA, 0, sector offset added to io_lba to form blk_lba (disk image position on card)
CAPACITY, 41056, number of sectors in the image; used only by SCSI_SD_BOUNDS_CHECK_EN

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
io_lba  input  32  sector address from SCSI target, valid while io_rd/io_wr high
io_rd  input  1  level request: read sector into target buffer
io_wr  input  1  level request: write target buffer to sector
io_ack  output  1  one-cycle completion pulse, registered
io_err  output  1  one-cycle error flag coincident with io_ack; constant 0 without the optional feature
sd_buff_addr  output  9  byte index into target buffers
sd_buff_dout  output  8  byte written into target inbound buffer
sd_buff_wr  output  1  write strobe for sd_buff_dout
sd_buff_din  input  8  byte from target outbound buffer, 1-cycle latency after sd_buff_addr
blk_lba  output  32  io_lba + BASE_LBA, latched at request accept
blk_rd  output  1  storage read command, held until blk_ack
blk_wr  output  1  storage write command, held until blk_ack
blk_ack  input  1  storage accepts command (1 cycle)
blk_din  input  8  read byte from storage
blk_din_valid  input  1  blk_din valid this cycle (no backpressure)
blk_dout  output  8  write byte to storage
blk_dout_valid  output  1  blk_dout valid
blk_dout_ready  input  1  storage consumes blk_dout when valid&ready

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; io_ack, io_err, sd_buff_wr, blk_rd, blk_wr, blk_dout_valid = 0; sd_buff_addr, byte counter = 0; blk_lba = 0. Reset mid-transfer abandons the sector: commands drop, no io_ack.
- States: IDLE, RD_CMD, RD_DATA, WR_CMD, WR_FETCH, WR_DATA, ACK.
- IDLE: io_rd=1 -> latch blk_lba = io_lba+BASE_LBA (mod 2^32), counter = 0 -> RD_CMD. Else io_wr=1 -> same latch -> WR_CMD. Both high: read wins.
- RD_CMD: blk_rd=1 with blk_lba stable. On blk_ack: blk_rd=0 next cycle -> RD_DATA.
- RD_DATA: each blk_din_valid cycle registers sd_buff_wr=1, sd_buff_dout=blk_din, sd_buff_addr=counter, then increments counter. The 512th byte (counter 511) -> ACK. Gaps in valid are allowed. Valid outside RD_DATA is ignored.
- WR_CMD: blk_wr=1 until blk_ack -> WR_FETCH.
- WR_FETCH: drive sd_buff_addr=counter; wait 1 cycle for sd_buff_din -> WR_DATA.
- WR_DATA: blk_dout=sd_buff_din (registered), blk_dout_valid=1, held stable until blk_dout_ready.
  - On handshake with counter<511: counter++ -> WR_FETCH.
  - At counter 511: -> ACK.
  - Minimum 2 cycles/byte.
- ACK: io_ack=1 for exactly one cycle -> IDLE. The target clears io_rd/io_wr on the edge ending the ACK cycle, so IDLE never re-accepts the same request.
- Counter is 10 bits; sd_buff_addr = counter[8:0]; no wrap within a sector.
- io_lba changes after accept are ignored.

Optional Feature:
SCSI_SD_BOUNDS_CHECK_EN
- Defined: in IDLE, a request with io_lba >= CAPACITY skips storage (no blk_rd/blk_wr, no buffer writes) and goes straight to ACK with io_err=1 alongside io_ack.
- Not defined: no check; io_err tied 0; every request reaches storage.

Decomposition:
Package scsi_sd_pkg:
- state enum
- SECTOR_BYTES=512
- SECTOR_AW=9

Single module, no sub-module: the FSM and byte counter are tightly shared.

Test Plan:
1. Read, BASE_LBA=100: io_rd=1, io_lba=5; storage acks after 3 cycles, sends bytes i&8'hFF -> blk_lba=105, 512 sd_buff_wr pulses at addr 0..511 with data 0..255,0..255, one io_ack, io_err=0.
2. Write with ready toggling every other cycle, buffer holds addr^8'h5A -> blk_wr until ack; 512 blk_dout bytes in order, each stable while valid&!ready; then one io_ack.
3. io_rd and io_wr asserted together, io_lba=7 -> read path only, blk_wr never asserted.
4. rst_n=0 after byte 200 of a read -> next cycle all outputs 0, state IDLE, no io_ack; a new io_rd then completes normally.
5. Bounds (macro on, CAPACITY=41056): io_rd, io_lba=41056 -> io_ack+io_err within 2 cycles, no blk_rd. io_lba=41055 -> normal read. Macro off -> 41056 reaches storage.
6. Back-to-back: target-model reissues io_rd immediately after ack -> second sector serviced, exactly two io_ack pulses total.
